// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - default widths, phase fold helper and quarter-wave table for the I/Q NCO
package dds_pkg;

    localparam int ACC_W_DEF  = 32;
    localparam int ADDR_W_DEF = 8;
    localparam int OUT_W_DEF  = 8;
    localparam int FM_W_DEF   = 16;
    localparam logic [ACC_W_DEF-1:0] FRQ_WORD_DEF = 32'd154404074;

    localparam int IDX_W = ADDR_W_DEF - 2;
    localparam int MAG_W = OUT_W_DEF - 1;
    localparam logic [ACC_W_DEF-1:0] QUARTER = {2'b01, {(ACC_W_DEF-2){1'b0}}};

    typedef struct packed {
        logic             neg;
        logic [IDX_W-1:0] idx;
    } fold_t;

    // Quadrant fold: mirror the index in odd quadrants, negate in the lower half-plane.
    function automatic fold_t fold(input logic [ACC_W_DEF-1:0] phase);
        fold_t            f;
        logic [IDX_W-1:0] i;
        i     = phase[ACC_W_DEF-3 -: IDX_W];
        f.neg = phase[ACC_W_DEF-1];
        f.idx = phase[ACC_W_DEF-2] ? ~i : i;
        return f;
    endfunction

    // round(127 * sin(2*pi*(k+0.5)/256)), k = 0..63; the half-LSB offset makes folding exact.
    localparam logic [MAG_W-1:0] QROM [0:(1<<IDX_W)-1] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

endpackage

// File: rtl/sin_qrom.sv
// rtl/sin_qrom.sv - dual-read-port synchronous quarter-wave sine magnitude ROM
module sin_qrom
    import dds_pkg::*;
(
    input  logic             clk,
    input  logic [IDX_W-1:0] addr_a,
    input  logic [IDX_W-1:0] addr_b,
    output logic [MAG_W-1:0] q_a,
    output logic [MAG_W-1:0] q_b
);

    always_ff @(posedge clk) begin
        q_a <= QROM[addr_a];
        q_b <= QROM[addr_b];
    end

endmodule

// File: rtl/dds_nco.sv
// rtl/dds_nco.sv - I/Q numerically-controlled oscillator with FM deviation and 3-stage lookup pipeline
module dds_nco_iq
    import dds_pkg::*;
#(
    parameter int               ACC_W   = dds_pkg::ACC_W_DEF,
    parameter int               ADDR_W  = dds_pkg::ADDR_W_DEF,
    parameter int               OUT_W   = dds_pkg::OUT_W_DEF,
    parameter int               FM_W    = dds_pkg::FM_W_DEF,
    parameter logic [ACC_W-1:0] FRQ_DEF = dds_pkg::FRQ_WORD_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    sync_clr,
    input  logic                    cfg_we,
    input  logic [ACC_W-1:0]        cfg_frq,
    input  logic [ACC_W-1:0]        cfg_phs,
    input  logic signed [FM_W-1:0]  fm_dev,
    output logic signed [OUT_W-1:0] o_sin,
    output logic signed [OUT_W-1:0] o_cos,
    output logic                    o_vld
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] frq_reg;
    logic [ACC_W-1:0] phs_reg;
    logic [ACC_W-1:0] fm_ext;
    logic [ACC_W-1:0] ps;
    logic [ACC_W-1:0] pc;

    fold_t            fs, fc;
    fold_t            fs1, fc1;
    logic             vld1, vld2;
    logic             neg_s2, neg_c2;
    logic [MAG_W-1:0] mag_s, mag_c;
    logic [OUT_W-1:0] sin_w, cos_w;

    assign fm_ext = {{(ACC_W-FM_W){fm_dev[FM_W-1]}}, fm_dev};
    assign ps     = acc + phs_reg;
    assign pc     = ps + QUARTER;
    assign fs     = fold(ps);
    assign fc     = fold(pc);

    // Reconfiguration never touches acc, so frequency changes stay phase-continuous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            frq_reg <= FRQ_DEF;
            phs_reg <= '0;
        end else begin
            if (sync_clr) begin
                acc <= '0;
            end else if (en) begin
                acc <= acc + frq_reg + fm_ext;
            end
            if (cfg_we) begin
                frq_reg <= cfg_frq;
                phs_reg <= cfg_phs;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fs1  <= '0;
            fc1  <= '0;
            vld1 <= 1'b0;
        end else begin
            fs1  <= fs;
            fc1  <= fc;
            vld1 <= en;
        end
    end

    sin_qrom u_qrom (
        .clk    (clk),
        .addr_a (fs1.idx),
        .addr_b (fc1.idx),
        .q_a    (mag_s),
        .q_b    (mag_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_s2 <= 1'b0;
            neg_c2 <= 1'b0;
            vld2   <= 1'b0;
        end else begin
            neg_s2 <= fs1.neg;
            neg_c2 <= fc1.neg;
            vld2   <= vld1;
        end
    end

    assign sin_w = neg_s2 ? (-{1'b0, mag_s}) : {1'b0, mag_s};
    assign cos_w = neg_c2 ? (-{1'b0, mag_c}) : {1'b0, mag_c};

    // Outputs only move on a valid sample and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sin <= '0;
            o_cos <= '0;
            o_vld <= 1'b0;
        end else begin
            o_vld <= vld2;
            if (vld2) begin
                o_sin <= sin_w;
                o_cos <= cos_w;
            end
        end
    end

endmodule
